// File: rtl/mac_timestep_scheduler_pkg.sv
// mac_timestep_scheduler_pkg: shared state encoding and widths for the MAC timestep scheduler
package mac_timestep_scheduler_pkg;
  typedef enum logic [2:0] {IDLE, INIT, COLLECT, CLEAR, WAIT_DONE} state_e;
  localparam int CNT_W = 8;
  localparam int TS_W = 16;
  localparam logic [11:0] DEF_NULL_ADDR = 12'hFFF;
endpackage

// File: rtl/mac_timestep_scheduler_spike_addr_fifo.sv
// spike_addr_fifo: synchronous FIFO with extra-MSB pointers, no read bypass
module spike_addr_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wptr_q, rptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic do_push, do_pop;
  assign empty_o = wptr_q == rptr_q;
  assign full_o = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_pop = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign rdata_o = mem_q[rptr_q[AW-1:0]];
  // pointer update; a full FIFO still accepts a push when it pops in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else if (flush_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop) rptr_q <= rptr_q + 1'b1;
    end
  end
  // storage write; contents need no reset since pointers gate visibility
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end
endmodule

// File: rtl/mac_timestep_scheduler.sv
// mac_timestep_scheduler: sequences MAC set, spike replay and end-of-timestep clear
module mac_timestep_scheduler import mac_timestep_scheduler_pkg::*; #(
  parameter int ADDR_W = 12,
  parameter int NUM_UNITS = 10,
  parameter int FIFO_DEPTH = 16,
  parameter int TIMESTEP_CYCLES = 64,
  parameter int INIT_CYCLES = 4,
  parameter int CLEAR_CYCLES = 2,
  parameter int DONE_TIMEOUT = 32,
  parameter logic [ADDR_W-1:0] NULL_ADDR = ADDR_W'(DEF_NULL_ADDR)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic                 stop_i,
  input  logic                 spike_valid_i,
  input  logic [ADDR_W-1:0]    spike_addr_i,
  output logic                 spike_ready_o,
  output logic                 mac_set_o,
  output logic                 mac_src_valid_o,
  output logic [ADDR_W-1:0]    mac_src_addr_o,
  output logic                 mac_clear_o,
  input  logic [NUM_UNITS-1:0] mac_done_i,
  output logic                 ts_done_o,
  output logic [TS_W-1:0]      timestep_count_o,
  output logic                 busy_o,
  output logic                 timeout_err_o
);
  localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TS_LAST = CNT_W'(TIMESTEP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CLR_LAST = CNT_W'(CLEAR_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(DONE_TIMEOUT - 1);
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, fifo_rdata;
  logic [TS_W-1:0] tcount_q;
  logic stop_q, set_q, clear_q, valid_q, ts_done_q, terr_q;
  logic fifo_full, fifo_empty, push, pop, flush, all_done, ts_evt, timeout;
  assign all_done = &mac_done_i;
  assign ts_evt = state_q == WAIT_DONE && (all_done || cnt_q == TO_LAST);
  assign timeout = state_q == WAIT_DONE && !all_done && cnt_q == TO_LAST;
  // the last COLLECT cycle does not pop so CLEAR never carries a live address
  assign pop = state_q == COLLECT && !fifo_empty && cnt_q != TS_LAST;
  assign spike_ready_o = !fifo_full && state_q != IDLE;
  assign push = spike_valid_i && spike_ready_o;
  assign flush = state_d == IDLE && state_q != IDLE;
  assign busy_o = state_q != IDLE;
  assign mac_set_o = set_q;
  assign mac_clear_o = clear_q;
  assign mac_src_valid_o = valid_q;
  assign mac_src_addr_o = addr_q;
  assign ts_done_o = ts_done_q;
  assign timestep_count_o = tcount_q;
  assign timeout_err_o = terr_q;
  spike_addr_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(ADDR_W)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .flush_i(flush),
    .push_i(push),
    .pop_i(pop),
    .wdata_i(spike_addr_i),
    .rdata_o(fifo_rdata),
    .full_o(fifo_full),
    .empty_o(fifo_empty)
  );
  // next state and per-state cycle counter, restarted on every state change
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      state_d = start_i ? INIT : IDLE;
      INIT:      state_d = cnt_q == INIT_LAST ? COLLECT : INIT;
      COLLECT:   state_d = cnt_q == TS_LAST ? CLEAR : COLLECT;
      CLEAR:     state_d = cnt_q == CLR_LAST ? WAIT_DONE : CLEAR;
      WAIT_DONE: state_d = !ts_evt ? WAIT_DONE : (stop_q || stop_i) ? IDLE : COLLECT;
      default:   state_d = IDLE;
    endcase
    cnt_d = (state_d != state_q || state_q == IDLE) ? '0 : cnt_q + 1'b1;
  end
  // FSM state, stop latch and registered outputs aligned with the new state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      stop_q <= 1'b0;
      set_q <= 1'b0;
      clear_q <= 1'b0;
      valid_q <= 1'b0;
      addr_q <= NULL_ADDR;
      ts_done_q <= 1'b0;
      tcount_q <= '0;
      terr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      stop_q <= state_d == IDLE ? 1'b0 : stop_q || (state_q != IDLE && stop_i);
      set_q <= state_d == INIT;
      clear_q <= state_d == CLEAR;
      valid_q <= pop;
      addr_q <= pop ? fifo_rdata : NULL_ADDR;
      ts_done_q <= ts_evt;
      if (ts_evt) tcount_q <= tcount_q + 1'b1;
      if (timeout) terr_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mac_timestep_scheduler.sv
// tb_mac_timestep_scheduler: directed self-checking bench for the MAC timestep scheduler
module tb_mac_timestep_scheduler;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, stop = 1'b0, spike_valid = 1'b0;
  logic [11:0] spike_addr = '0;
  logic [9:0] mac_done = '0;
  logic spike_ready, mac_set, mac_src_valid, mac_clear, ts_done, busy, timeout_err;
  logic [11:0] mac_src_addr;
  logic [15:0] timestep_count;
  int checks = 0, failures = 0, cyc = 0, col0 = 0, p = 0, n = 0;
  logic r, v;

  mac_timestep_scheduler dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .stop_i(stop),
    .spike_valid_i(spike_valid), .spike_addr_i(spike_addr), .spike_ready_o(spike_ready),
    .mac_set_o(mac_set), .mac_src_valid_o(mac_src_valid), .mac_src_addr_o(mac_src_addr),
    .mac_clear_o(mac_clear), .mac_done_i(mac_done), .ts_done_o(ts_done),
    .timestep_count_o(timestep_count), .busy_o(busy), .timeout_err_o(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_bus(input string tag, input logic [11:0] a, input logic vld);
    check({tag, "_addr"}, mac_src_addr, a);
    check({tag, "_vld"}, mac_src_valid, vld);
  endtask

  initial begin
    tick();
    tick();
    check("rst_busy", busy, 0);
    check("rst_set", mac_set, 0);
    check("rst_clear", mac_clear, 0);
    check_bus("rst", 12'hFFF, 0);
    check("rst_ready", spike_ready, 0);
    check("rst_count", timestep_count, 0);
    check("rst_terr", timeout_err, 0);
    check("rst_tsdone", ts_done, 0);
    rst_n = 1'b1;
    tick();
    check("idle_busy", busy, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("init_set0", mac_set, 1);
    check("init_ready", spike_ready, 1);
    for (int i = 1; i < 4; i++) begin
      tick();
      check("init_set", mac_set, 1);
    end
    tick();
    check("init_end", mac_set, 0);
    check("collect_busy", busy, 1);
    col0 = cyc;
    spike_valid = 1'b1;
    spike_addr = 12'd3;
    tick();
    spike_valid = 1'b0;
    check_bus("no_bypass", 12'hFFF, 0);
    tick();
    check_bus("pop3", 12'd3, 1);
    tick();
    check_bus("idle1", 12'hFFF, 0);
    spike_valid = 1'b1;
    spike_addr = 12'd7;
    tick();
    spike_addr = 12'd13;
    tick();
    check_bus("pop7", 12'd7, 1);
    spike_valid = 1'b0;
    tick();
    check_bus("pop13", 12'd13, 1);
    tick();
    check_bus("idle2", 12'hFFF, 0);
    for (n = 0; n < 100 && !mac_clear; n++) tick();
    check("clear_seen", mac_clear, 1);
    check("clear_elapsed", cyc - col0, 64);
    check_bus("clear_bus", 12'hFFF, 0);
    for (int i = 0; i < 16; i++) begin
      spike_valid = 1'b1;
      spike_addr = 12'(100 + i);
      r = spike_ready;
      tick();
      check("fill_ready", r, 1);
      if (i == 0) check("clear_c1", mac_clear, 1);
      if (i == 1) check("clear_off", mac_clear, 0);
    end
    check("full_ready", spike_ready, 0);
    spike_addr = 12'd116;
    for (n = 0; n < 40 && !ts_done; n++) tick();
    check("wait_len", 14 + n, 32);
    check("to_tsdone", ts_done, 1);
    check("to_terr", timeout_err, 1);
    check("to_count", timestep_count, 1);
    check("to_busy", busy, 1);
    col0 = cyc;
    p = 16;
    for (int k = 0; k < 20; k++) begin
      v = p < 20;
      spike_valid = v;
      spike_addr = 12'(100 + p);
      r = spike_ready;
      tick();
      if (v && r) p++;
      check_bus("drain", 12'(100 + k), 1);
      if (k == 0) check("tsdone_pulse", ts_done, 0);
    end
    spike_valid = 1'b0;
    check("drain_pushed", p, 20);
    tick();
    check_bus("drain_end", 12'hFFF, 0);
    mac_done = '1;
    while (cyc < col0 + 63) tick();
    spike_valid = 1'b1;
    spike_addr = 12'd13;
    tick();
    spike_valid = 1'b0;
    check("late_clear", mac_clear, 1);
    check_bus("late_clr_bus", 12'hFFF, 0);
    tick();
    tick();
    check_bus("late_wait_bus", 12'hFFF, 0);
    tick();
    check("late_tsdone", ts_done, 1);
    check("late_count", timestep_count, 2);
    check_bus("late_c0", 12'hFFF, 0);
    col0 = cyc;
    tick();
    check_bus("late_c1", 12'd13, 1);
    check("terr_sticky", timeout_err, 1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stop_busy", busy, 1);
    while (cyc < col0 + 63) tick();
    spike_valid = 1'b1;
    spike_addr = 12'd55;
    tick();
    spike_valid = 1'b0;
    for (n = 0; n < 10 && !ts_done; n++) tick();
    check("stop_tsdone", ts_done, 1);
    check("stop_idle", busy, 0);
    check("stop_count", timestep_count, 3);
    check("stop_ready", spike_ready, 0);
    start = 1'b1;
    stop = 1'b1;
    tick();
    start = 1'b0;
    stop = 1'b0;
    check("startwins_set", mac_set, 1);
    check("startwins_busy", busy, 1);
    for (int i = 0; i < 6; i++) tick();
    check_bus("flushed", 12'hFFF, 0);
    for (n = 0; n < 100 && !ts_done; n++) tick();
    check("run2_tsdone", ts_done, 1);
    check("run2_count", timestep_count, 4);
    check("stop_not_latched", busy, 1);
    for (n = 0; n < 100 && !mac_clear; n++) tick();
    check("run2_clear", mac_clear, 1);
    rst_n = 1'b0;
    #1;
    check("abort_clear", mac_clear, 0);
    check("abort_busy", busy, 0);
    check("abort_count", timestep_count, 0);
    check("abort_terr", timeout_err, 0);
    check_bus("abort", 12'hFFF, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
